conv_kernel: RTL and testbench
==============================

CONV_KERNEL -- requirements
Module: conv_kernel

Interface
REQ-001 The block SHALL have exactly one clock domain; rst_n is a synchronous, active-high reset (name kept per codebase; the _n suffix does not imply low polarity).
REQ-002 Ports SHALL be:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-high reset
- d_in1  input  32  signed pixel, window row 0 of the incoming column
- d_in2  input  32  signed pixel, row 1
- d_in3  input  32  signed pixel, row 2
- d_in4  input  32  signed pixel, row 3
- d_in5  input  32  signed pixel, row 4
- in_valid  input  1  column d_in1..d_in5 is valid this cycle
- w_in  input  800  25 signed 32-bit weights; w[k] = w_in[32k+31:32k], k = 5*row + col
- b_in  input  32  signed bias
- d_out  output  32  signed convolution result
- out_valid  output  1  d_out valid, one-cycle pulse per result
REQ-003 The block SHALL have no parameters; all widths are fixed as above.

Function
REQ-004 The block SHALL hold a 5x5 window P[row][col]; col 4 is the newest column, col 0 the oldest.
REQ-005 On each clk edge with in_valid=1, the window SHALL shift one column (col c <- col c+1) and load d_in1..d_in5 into col 4, rows 0..4.
REQ-006 With in_valid=0, the window SHALL hold; bubbles SHALL NOT alter any later result.
REQ-007 A fill counter SHALL count accepted columns since reset, saturating at 5.
REQ-008 A beat SHALL be "productive" when in_valid=1 and the counter, including this beat, reaches 5.
REQ-009 Result SHALL be d_out = b_in + sum over row,col of P[row][col]*w[5*row+col], with P taken after the productive beat.
REQ-010 Arithmetic SHALL be two's complement; each product keeps its low 32 bits; all sums wrap modulo 2^32 with no saturation.
REQ-011 The pipeline SHALL have 3 stages: edge T captures the column; edge T+1 registers 25 products; edge T+2 registers d_out and the adder tree plus bias.
REQ-012 out_valid SHALL be high for exactly the one cycle following edge T+2 of each productive beat.
REQ-013 Back-to-back productive beats SHALL give back-to-back out_valid pulses (throughput 1 result/clock).
REQ-014 d_out SHALL hold its last value when out_valid=0.
REQ-015 w_in and b_in SHALL be sampled at edge T+1 (products) and edge T+2 (bias) respectively; they are static during operation.

Reset
REQ-016 When rst_n=1 at a clk edge, the block SHALL clear the window, fill counter, product registers and pipeline valid bits, and set d_out=0 and out_valid=0.
REQ-017 Reset SHALL take priority over in_valid.
REQ-018 Results in flight SHALL be discarded by reset.
REQ-019 After reset, the first out_valid SHALL require 5 new accepted columns.
REQ-020 Before rst_n is first asserted, output values are unspecified.

Verification
REQ-021 Weights per row {col0..col4}={1,2,3,4,5}, bias 1, all d_in=1, in_valid high 5 cycles -> one out_valid 2 clocks after the 5th beat, d_out=76.
REQ-022 Same weights and bias; columns 1,2,3,4,5 (all rows equal), continuous in_valid -> first d_out=276; sixth column 6 -> next cycle d_out=351.
REQ-023 Same stream as REQ-022 with in_valid toggling every cycle (bubbles) -> identical d_out values; out_valid only 2 clocks after each productive beat.
REQ-024 All weights 0xFFFFFFFF, bias 0, all d_in=2 -> d_out=0xFFFFFFCE (-50).
REQ-025 All weights 4, all d_in=0x40000000, bias 7 -> d_out=7 (product wrap).
REQ-026 Reset asserted after 3 accepted columns, then 4 columns -> no out_valid; 5th column -> out_valid; also no out_valid from a result in flight at reset.

Source files
------------

// File: rtl/conv_kernel.sv
// 5x5 sliding-window convolution: columns shift in from the right, 25 products
// are registered, then an adder tree plus bias produces one result per productive beat.
module conv_kernel (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  d_in1,
  input  logic [31:0]  d_in2,
  input  logic [31:0]  d_in3,
  input  logic [31:0]  d_in4,
  input  logic [31:0]  d_in5,
  input  logic         in_valid,
  input  logic [799:0] w_in,
  input  logic [31:0]  b_in,
  output logic [31:0]  d_out,
  output logic         out_valid
);

  logic [31:0] win_q [5][5];
  logic [31:0] col_in [5];
  logic [2:0]  fill_q;
  logic [2:0]  fill_d;
  logic        productive;
  logic        v1_q;
  logic        v2_q;
  logic [31:0] prod_d [25];
  logic [31:0] prod_q [25];
  logic [31:0] sum_d;

  assign col_in[0] = d_in1;
  assign col_in[1] = d_in2;
  assign col_in[2] = d_in3;
  assign col_in[3] = d_in4;
  assign col_in[4] = d_in5;

  // The beat that completes (or follows) the fifth accepted column is productive.
  assign productive = in_valid && (fill_q >= 3'd4);
  assign fill_d     = (in_valid && (fill_q != 3'd5)) ? fill_q + 3'd1 : fill_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      fill_q <= '0;
      v1_q   <= 1'b0;
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      fill_q <= fill_d;
      v1_q   <= productive;
      if (in_valid) begin
        for (int r = 0; r < 5; r++) begin
          for (int c = 0; c < 4; c++) begin
            win_q[r][c] <= win_q[r][c+1];
          end
          win_q[r][4] <= col_in[r];
        end
      end
    end
  end

  // Only the low 32 bits of each product are kept, so unsigned multiply suffices.
  genvar gi;
  generate
    for (gi = 0; gi < 25; gi++) begin : g_prod
      assign prod_d[gi] = win_q[gi / 5][gi % 5] * w_in[32*gi +: 32];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst_n) begin
      v2_q <= 1'b0;
      for (int k = 0; k < 25; k++) begin
        prod_q[k] <= '0;
      end
    end else begin
      v2_q <= v1_q;
      for (int k = 0; k < 25; k++) begin
        prod_q[k] <= prod_d[k];
      end
    end
  end

  always_comb begin
    sum_d = b_in;
    for (int k = 0; k < 25; k++) begin
      sum_d = sum_d + prod_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      d_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= v2_q;
      if (v2_q) begin
        d_out <= sum_d;
      end
    end
  end

endmodule

// File: tb/tb_conv_kernel.sv
// Randomized and directed bench for conv_kernel against a column-history model.
module tb_conv_kernel;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [31:0]  d_in1 = '0, d_in2 = '0, d_in3 = '0, d_in4 = '0, d_in5 = '0;
  logic         in_valid = 1'b0;
  logic [799:0] w_in = '0;
  logic [31:0]  b_in = '0;
  logic [31:0]  d_out;
  logic         out_valid;

  conv_kernel dut (
    .clk(clk), .rst_n(rst_n),
    .d_in1(d_in1), .d_in2(d_in2), .d_in3(d_in3), .d_in4(d_in4), .d_in5(d_in5),
    .in_valid(in_valid), .w_in(w_in), .b_in(b_in),
    .d_out(d_out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef bit [4:0][31:0] col_t;
  typedef struct { int e; bit [31:0] v; } exp_t;

  int          checks = 0;
  int          passed = 0;
  int          edge_cnt = 0;
  int          fill = 0;
  col_t        hist[$];
  exp_t        expq[$];
  bit [31:0]   obs_q[$];
  bit [31:0]   w_arr [25];
  bit [31:0]   bias = 0;
  bit [31:0]   last_exp = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, edge_cnt);
  endtask

  task automatic apply_w(input bit [31:0] b);
    for (int k = 0; k < 25; k++) w_in[32*k +: 32] = w_arr[k];
    bias = b;
    b_in = b;
  endtask

  function automatic col_t col_all(input bit [31:0] x);
    col_t c;
    for (int r = 0; r < 5; r++) c[r] = x;
    return c;
  endfunction

  // Convolution of the last five accepted columns; hist[0] is the oldest.
  function automatic bit [31:0] model_result();
    bit [31:0] acc = bias;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        acc = acc + hist[c][r] * w_arr[5*r + c];
    return acc;
  endfunction

  task automatic step(input bit v, input col_t col);
    bit ov_exp;
    in_valid = v;
    d_in1 = col[0]; d_in2 = col[1]; d_in3 = col[2]; d_in4 = col[3]; d_in5 = col[4];
    @(posedge clk);
    edge_cnt++;
    if (v) begin
      hist.push_back(col);
      if (hist.size() > 5) void'(hist.pop_front());
      if (fill < 5) fill++;
      if (fill == 5) expq.push_back('{e: edge_cnt, v: model_result()});
    end
    #1;
    ov_exp = (expq.size() > 0) && (expq[0].e + 2 == edge_cnt);
    if (ov_exp) begin
      last_exp = expq[0].v;
      void'(expq.pop_front());
    end
    check("out_valid", {31'b0, out_valid}, {31'b0, ov_exp});
    check("d_out", d_out, last_exp);
    if (out_valid) obs_q.push_back(d_out);
    $display("edge %0d in_valid=%0b out_valid=%0b d_out=%h", edge_cnt, v, out_valid, d_out);
  endtask

  task automatic do_reset(input bit iv);
    rst_n = 1'b1;
    in_valid = iv;
    @(posedge clk);
    edge_cnt++;
    hist.delete(); expq.delete(); fill = 0; last_exp = 0;
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_d_out", d_out, 32'd0);
    $display("edge %0d reset", edge_cnt);
    rst_n = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, col_t'($urandom));
  endtask

  task automatic set_rows_12345();
    for (int k = 0; k < 25; k++) w_arr[k] = 32'(k % 5 + 1);
  endtask

  initial begin
    col_t rc;
    int   nobs;

    do_reset(1'b0);

    // Basic all-ones window
    set_rows_12345();
    apply_w(32'd1);
    obs_q.delete();
    for (int i = 0; i < 5; i++) step(1'b1, col_all(32'd1));
    drain(3);
    check("ones_count", obs_q.size(), 32'd1);
    if (obs_q.size() > 0) check("ones_value", obs_q[0], 32'd76);

    // Ramp with continuous valid
    do_reset(1'b0);
    obs_q.delete();
    for (int i = 1; i <= 6; i++) step(1'b1, col_all(32'(i)));
    drain(3);
    check("ramp_count", obs_q.size(), 32'd2);
    if (obs_q.size() > 1) begin
      check("ramp_first", obs_q[0], 32'd276);
      check("ramp_second", obs_q[1], 32'd351);
    end

    // Same ramp with bubbles
    do_reset(1'b0);
    obs_q.delete();
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, col_all(32'(i)));
      step(1'b0, col_all(32'hDEAD_BEEF));
    end
    drain(3);
    check("bubble_count", obs_q.size(), 32'd2);
    if (obs_q.size() > 1) begin
      check("bubble_first", obs_q[0], 32'd276);
      check("bubble_second", obs_q[1], 32'd351);
    end

    // Negative weights
    do_reset(1'b0);
    for (int k = 0; k < 25; k++) w_arr[k] = 32'hFFFF_FFFF;
    apply_w(32'd0);
    obs_q.delete();
    for (int i = 0; i < 5; i++) step(1'b1, col_all(32'd2));
    drain(3);
    if (obs_q.size() > 0) check("neg_value", obs_q[0], 32'hFFFF_FFCE);
    else check("neg_count", 32'd0, 32'd1);

    // Product wrap
    do_reset(1'b0);
    for (int k = 0; k < 25; k++) w_arr[k] = 32'd4;
    apply_w(32'd7);
    obs_q.delete();
    for (int i = 0; i < 5; i++) step(1'b1, col_all(32'h4000_0000));
    drain(3);
    if (obs_q.size() > 0) check("wrap_value", obs_q[0], 32'd7);
    else check("wrap_count", 32'd0, 32'd1);

    // Reset after 3 columns, with in_valid high during reset
    set_rows_12345();
    apply_w(32'd1);
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, col_all(32'($urandom)));
    do_reset(1'b1);
    obs_q.delete();
    for (int i = 0; i < 4; i++) step(1'b1, col_all(32'($urandom)));
    drain(2);
    check("partial_none", obs_q.size(), 32'd0);
    step(1'b1, col_all(32'd9));
    drain(3);
    check("partial_fifth", obs_q.size(), 32'd1);

    // Result in flight discarded by reset
    for (int i = 0; i < 2; i++) step(1'b1, col_all(32'($urandom)));
    do_reset(1'b0);
    obs_q.delete();
    drain(4);
    check("inflight_none", obs_q.size(), 32'd0);

    // Randomized weights, bias, data and valid pattern
    for (int round = 0; round < 3; round++) begin
      do_reset(1'b0);
      for (int k = 0; k < 25; k++) w_arr[k] = $urandom;
      apply_w($urandom);
      for (int i = 0; i < 150; i++) begin
        for (int r = 0; r < 5; r++) rc[r] = $urandom;
        step(($urandom_range(0, 3) != 0), rc);
      end
      drain(3);
      check("rand_queue_empty", expq.size(), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
